uart_rx: RTL and testbench

//   8N1 UART receiver: the receive-side counterpart of the UART_TX transmitter, same frame format and bit timing.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_sync2.sv | 22 ++
 rtl/uart_rx.sv | 144 ++++++++++++++
 tb/tb_uart_rx.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: bit-timing defaults, divider helper and the
// receiver state encoding. Used by both the RX and TX sides.
package uart_pkg;

    localparam int UART_CLK_FREQ = 50_000_000;
    localparam int UART_BAUD     = 115_200;

    // Clocks per bit, truncating like the TX so both ends agree exactly.
    function automatic int uart_div(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } rx_state_t;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an asynchronous level input; resets high.
// Ports: clk, rst (sync, active high), d (async in), q (synchronised out).
module uart_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: start-edge detect, mid-bit 3-sample majority vote,
// LSB-first assembly, one-cycle valid strobe and framing-error strobe.
// Ports: clk, rst (sync, active high), rxd (async line, idle high),
//        rx_data[7:0], rx_data_valid, rx_busy, rx_frame_err.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = UART_CLK_FREQ,
    parameter int BAUD     = UART_BAUD
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic [7:0] rx_data,
    output logic       rx_data_valid,
    output logic       rx_busy,
    output logic       rx_frame_err
);

    localparam int DIV = uart_div(CLK_FREQ, BAUD);
    localparam int CW  = $clog2(DIV);

    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
    localparam logic [CW-1:0] SMP_LO   = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0] SMP_HI   = CW'(DIV / 2 + 1);
    localparam logic [CW-1:0] CNT_DEC  = CW'(DIV / 2 + 2);

    rx_state_t     state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [2:0]    idx, idx_d;
    logic [7:0]    shift, shift_d;
    logic [2:0]    smp, smp_d;
    logic [7:0]    data_d;
    logic          valid_d, err_d;

    logic          rxd_s, rxd_q;
    logic [1:0]    settle;
    logic          fall, vote;
    logic          cnt_wrap, at_dec, in_win;

    uart_sync2 u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rxd),
        .q   (rxd_s)
    );

    // The synchroniser and edge flop power up high, so a line held low
    // through reset would look like a falling edge. Edge detection is
    // armed only once both stages carry real line samples.
    assign fall = (settle == 2'd3) && rxd_q && !rxd_s;

    assign vote = (smp[0] & smp[1]) | (smp[0] & smp[2]) | (smp[1] & smp[2]);

    assign cnt_wrap = (cnt == CNT_LAST);
    assign at_dec   = (cnt == CNT_DEC);
    assign in_win   = (cnt >= SMP_LO) && (cnt <= SMP_HI);

    assign rx_busy = (state != IDLE);

    always_comb begin
        state_d = state;
        cnt_d   = cnt_wrap ? '0 : cnt + CW'(1);
        idx_d   = idx;
        shift_d = shift;
        smp_d   = in_win ? {smp[1:0], rxd_s} : smp;
        data_d  = rx_data;
        valid_d = 1'b0;
        err_d   = 1'b0;

        unique case (state)
            IDLE: begin
                cnt_d = '0;
                if (fall) state_d = START;
            end
            START: begin
                if (at_dec && vote) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_wrap) begin
                    state_d = DATA;
                    idx_d   = '0;
                end
            end
            DATA: begin
                if (at_dec) shift_d[idx] = vote;
                if (cnt_wrap) begin
                    if (idx == 3'd7) state_d = STOP;
                    else             idx_d   = idx + 3'd1;
                end
            end
            STOP: begin
                // Leaving at mid-stop leaves half a bit to catch the
                // next start edge of a back-to-back frame.
                if (at_dec) begin
                    cnt_d = '0;
                    if (vote) begin
                        data_d  = shift;
                        valid_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = BREAK;
                    end
                end
            end
            BREAK: begin
                cnt_d = '0;
                if (rxd_s) state_d = IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            idx           <= '0;
            shift         <= '0;
            smp           <= '0;
            rx_data       <= 8'h00;
            rx_data_valid <= 1'b0;
            rx_frame_err  <= 1'b0;
            rxd_q         <= 1'b1;
            settle        <= '0;
        end else begin
            state         <= state_d;
            cnt           <= cnt_d;
            idx           <= idx_d;
            shift         <= shift_d;
            smp           <= smp_d;
            rx_data       <= data_d;
            rx_data_valid <= valid_d;
            rx_frame_err  <= err_d;
            rxd_q         <= rxd_s;
            if (settle != 2'd3) settle <= settle + 2'd1;
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: drives 8N1 frames on rxd and checks
// received bytes, strobes and timing against a frame-level model.
module tb_uart_rx;

    localparam int DIV = 50_000_000 / 115_200;
    // First clock edge after the fall, plus the documented latency.
    localparam int LAT = 1 + 2 + 9 * DIV + DIV / 2 + 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rxd = 1'b1;
    logic [7:0] rx_data;
    logic       rx_data_valid;
    logic       rx_busy;
    logic       rx_frame_err;

    int checks = 0;
    int passed = 0;
    int cyc    = 0;

    logic [7:0] got_data[$];
    int         got_cyc[$];
    int         err_cnt, err_cyc, both_total;
    bit         busy_seen;
    logic [7:0] model_data;

    uart_rx dut (
        .clk           (clk),
        .rst           (rst),
        .rxd           (rxd),
        .rx_data       (rx_data),
        .rx_data_valid (rx_data_valid),
        .rx_busy       (rx_busy),
        .rx_frame_err  (rx_frame_err)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (rx_data_valid) begin
                got_data.push_back(rx_data);
                got_cyc.push_back(cyc);
            end
            if (rx_frame_err) begin
                err_cnt++;
                err_cyc = cyc;
            end
            if (rx_data_valid && rx_frame_err) both_total++;
            if (rx_busy) busy_seen = 1'b1;
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_mon();
        got_data.delete();
        got_cyc.delete();
        err_cnt   = 0;
        err_cyc   = 0;
        busy_seen = 1'b0;
    endtask

    // One 8N1 frame; optional one-clock inverted spike mid data bit.
    task automatic send_frame(input logic [7:0] b, input logic stop_v,
                              input int spike_bit, output int t_fall);
        t_fall = cyc;
        rxd = 1'b0;
        wait_cyc(DIV);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            if (i == spike_bit) begin
                wait_cyc(DIV / 2);
                rxd = ~b[i];
                wait_cyc(1);
                rxd = b[i];
                wait_cyc(DIV - DIV / 2 - 1);
            end else begin
                wait_cyc(DIV);
            end
        end
        rxd = stop_v;
        wait_cyc(DIV);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rxd = 1'b1;
        wait_cyc(2);
        checks++;
        if (rx_data !== 8'h00) $display("FAIL reset_data got %h exp 00", rx_data);
        else passed++;
        checks++;
        if (rx_data_valid !== 1'b0) $display("FAIL reset_valid got %b exp 0", rx_data_valid);
        else passed++;
        checks++;
        if (rx_busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", rx_busy);
        else passed++;
        checks++;
        if (rx_frame_err !== 1'b0) $display("FAIL reset_err got %b exp 0", rx_frame_err);
        else passed++;
        rst = 1'b0;
        model_data = 8'h00;
        wait_cyc(10);
    endtask

    task automatic test_low_from_reset();
        rst = 1'b1;
        rxd = 1'b0;
        wait_cyc(2);
        rst = 1'b0;
        clear_mon();
        wait_cyc(DIV);
        checks++;
        if (busy_seen !== 1'b0) $display("FAIL low_reset_busy got %b exp 0", busy_seen);
        else passed++;
        rxd = 1'b1;
        wait_cyc(10);
    endtask

    task automatic test_single();
        int tf;
        clear_mon();
        send_frame(8'h96, 1'b1, -1, tf);
        wait_cyc(8);
        model_data = 8'h96;
        checks++;
        if (got_data.size() != 1) $display("FAIL single_count got %0d exp 1", got_data.size());
        else passed++;
        checks++;
        if (got_data.size() < 1 || got_data[0] !== 8'h96)
            $display("FAIL single_data got %h exp 96", rx_data);
        else passed++;
        checks++;
        if (got_cyc.size() < 1 || got_cyc[0] != tf + LAT)
            $display("FAIL single_latency got %0d exp %0d",
                     got_cyc.size() ? got_cyc[0] - tf : -1, LAT);
        else passed++;
        checks++;
        if (err_cnt != 0) $display("FAIL single_err got %0d exp 0", err_cnt);
        else passed++;
    endtask

    task automatic test_back_to_back();
        int t0, t1;
        clear_mon();
        send_frame(8'h96, 1'b1, -1, t0);
        send_frame(8'h76, 1'b1, -1, t1);
        wait_cyc(8);
        model_data = 8'h76;
        checks++;
        if (got_data.size() != 2) $display("FAIL b2b_count got %0d exp 2", got_data.size());
        else passed++;
        checks++;
        if (got_data.size() < 2 || got_data[0] !== 8'h96 || got_data[1] !== 8'h76)
            $display("FAIL b2b_data got %h exp 96,76", rx_data);
        else passed++;
        checks++;
        if (got_cyc.size() < 2 || got_cyc[1] - got_cyc[0] != 10 * DIV)
            $display("FAIL b2b_spacing got %0d exp %0d",
                     got_cyc.size() > 1 ? got_cyc[1] - got_cyc[0] : -1, 10 * DIV);
        else passed++;
        checks++;
        if (got_cyc.size() < 2 || got_cyc[1] != t1 + LAT)
            $display("FAIL b2b_latency2 got %0d exp %0d",
                     got_cyc.size() > 1 ? got_cyc[1] - t1 : -1, LAT);
        else passed++;
    endtask

    task automatic test_glitch();
        clear_mon();
        rxd = 1'b0;
        wait_cyc(DIV * 3 / 10);
        rxd = 1'b1;
        wait_cyc(2 * DIV);
        checks++;
        if (busy_seen !== 1'b1) $display("FAIL glitch_busy got %b exp 1", busy_seen);
        else passed++;
        checks++;
        if (rx_busy !== 1'b0) $display("FAIL glitch_idle got %b exp 0", rx_busy);
        else passed++;
        checks++;
        if (got_data.size() != 0 || err_cnt != 0)
            $display("FAIL glitch_pulses got %0d/%0d exp 0/0", got_data.size(), err_cnt);
        else passed++;
    endtask

    task automatic test_frame_err();
        int tf;
        clear_mon();
        send_frame(8'h55, 1'b0, -1, tf);
        wait_cyc(3 * DIV);
        rxd = 1'b1;
        wait_cyc(DIV);
        checks++;
        if (err_cnt != 1) $display("FAIL ferr_count got %0d exp 1", err_cnt);
        else passed++;
        checks++;
        if (err_cyc != tf + LAT) $display("FAIL ferr_time got %0d exp %0d", err_cyc - tf, LAT);
        else passed++;
        checks++;
        if (got_data.size() != 0) $display("FAIL ferr_valid got %0d exp 0", got_data.size());
        else passed++;
        checks++;
        if (rx_data !== model_data) $display("FAIL ferr_hold got %h exp %h", rx_data, model_data);
        else passed++;
        clear_mon();
        send_frame(8'hA5, 1'b1, -1, tf);
        wait_cyc(8);
        model_data = 8'hA5;
        checks++;
        if (got_data.size() != 1 || got_data[0] !== 8'hA5)
            $display("FAIL ferr_recover got %h exp a5", rx_data);
        else passed++;
    endtask

    task automatic test_spike();
        int tf;
        clear_mon();
        send_frame(8'h0F, 1'b1, 3, tf);
        wait_cyc(8);
        model_data = 8'h0F;
        checks++;
        if (got_data.size() != 1 || got_data[0] !== 8'h0F)
            $display("FAIL spike_data got %h exp 0f", rx_data);
        else passed++;
    endtask

    task automatic test_reset_mid();
        int tf;
        clear_mon();
        fork
            send_frame(8'hC3, 1'b1, -1, tf);
            begin
                wait_cyc(5 * DIV + DIV / 2);
                rst = 1'b1;
                wait_cyc(1);
                checks++;
                if (rx_data !== 8'h00 || rx_data_valid !== 1'b0 ||
                    rx_busy !== 1'b0 || rx_frame_err !== 1'b0)
                    $display("FAIL midrst_outs got %h%b%b%b exp 00000",
                             rx_data, rx_data_valid, rx_busy, rx_frame_err);
                else passed++;
                wait_cyc(1);
                rst = 1'b0;
            end
        join
        model_data = 8'h00;
        wait_cyc(DIV);
        checks++;
        if (got_data.size() != 0 || err_cnt != 0)
            $display("FAIL midrst_pulses got %0d/%0d exp 0/0", got_data.size(), err_cnt);
        else passed++;
        clear_mon();
        send_frame(8'h3C, 1'b1, -1, tf);
        wait_cyc(8);
        model_data = 8'h3C;
        checks++;
        if (got_data.size() != 1 || got_data[0] !== 8'h3C)
            $display("FAIL midrst_next got %h exp 3c", rx_data);
        else passed++;
    endtask

    task automatic test_random();
        logic [7:0] exp_q[$];
        int         exp_t[$];
        logic [7:0] b;
        int         tf;
        clear_mon();
        for (int n = 0; n < 6; n++) begin
            b = 8'($urandom);
            send_frame(b, 1'b1, -1, tf);
            exp_q.push_back(b);
            exp_t.push_back(tf + LAT);
            if ($urandom_range(1, 0) == 1) wait_cyc($urandom_range(DIV, 1));
        end
        wait_cyc(8);
        model_data = exp_q[$];
        checks++;
        if (got_data.size() != exp_q.size())
            $display("FAIL rand_count got %0d exp %0d", got_data.size(), exp_q.size());
        else passed++;
        for (int n = 0; n < exp_q.size(); n++) begin
            checks++;
            if (n >= got_data.size() || got_data[n] !== exp_q[n] || got_cyc[n] != exp_t[n])
                $display("FAIL rand_frame%0d got %h exp %h", n,
                         n < got_data.size() ? got_data[n] : 8'hxx, exp_q[n]);
            else passed++;
        end
        checks++;
        if (rx_data !== model_data) $display("FAIL rand_hold got %h exp %h", rx_data, model_data);
        else passed++;
        checks++;
        if (both_total != 0) $display("FAIL valid_and_err got %0d exp 0", both_total);
        else passed++;
    endtask

    initial begin
        err_cnt    = 0;
        err_cyc    = 0;
        both_total = 0;
        busy_seen  = 1'b0;
        model_data = 8'h00;
        test_reset();
        test_low_from_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_frame_err();
        test_spike();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
